// File: rtl/onn_pkg.sv
// ============================================================================
// Module   : onn_pkg
// Brief    : Shared constants and types for the oscillatory neuron fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package onn_pkg;

    localparam int PHASE_W = 4;
    localparam int PERIOD  = 16;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t PHASE_MAX = phase_t'(PERIOD - 1);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } osc_state_t;

endpackage : onn_pkg

`default_nettype wire

// File: rtl/neuron_osc_if.sv
// ============================================================================
// Module   : neuron_osc_if
// Brief    : Valid/ready phase-adjust request channel into a neuron oscillator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface neuron_osc_if;
    import onn_pkg::*;

    logic   adj_valid;
    logic   adj_dir;
    phase_t adj_amt;
    logic   adj_ready;

    modport master (
        output adj_valid,
        output adj_dir,
        output adj_amt,
        input  adj_ready
    );

    modport slave (
        input  adj_valid,
        input  adj_dir,
        input  adj_amt,
        output adj_ready
    );

endinterface : neuron_osc_if

`default_nettype wire

// File: rtl/neuron_osc.sv
// ============================================================================
// Module   : neuron_osc
// Brief    : Mod-16 phase oscillator with spike output, phase load and
//            wrap-time advance/retard adjustment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_osc
    import onn_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         phase_load,
    input  phase_t       phase_in,
    neuron_osc_if.slave  adj,
    output logic         spike,
    output phase_t       phase,
    output logic         holding
);

    osc_state_t state_q,   state_d;
    osc_state_t resume_q,  resume_d;
    phase_t     cnt_q,     cnt_d;
    phase_t     hold_q,    hold_d;
    logic       pend_q,    pend_d;
    logic       pdir_q,    pdir_d;
    phase_t     pamt_q,    pamt_d;
    logic       spike_q,   spike_d;
    logic       holding_q, holding_d;

    logic       w_xfer;
    osc_state_t w_act;

    assign w_xfer = adj.adj_valid && !pend_q;

    // A stopped oscillator remembers whether it was counting or holding.
    assign w_act  = (state_q == STOP) ? resume_q : state_q;

    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        pdir_d    = pdir_q;
        pamt_d    = pamt_q;
        spike_d   = 1'b0;

        if (phase_load) begin
            cnt_d    = phase_in;
            hold_d   = '0;
            pend_d   = 1'b0;
            resume_d = RUN;
            state_d  = en ? RUN : STOP;
        end else begin
            if (!en) begin
                if (state_q != STOP) begin
                    resume_d = state_q;
                end
                state_d = STOP;
            end else begin
                state_d = w_act;
                case (w_act)
                    HOLD: begin
                        if (hold_q == phase_t'(1)) begin
                            hold_d  = '0;
                            state_d = RUN;
                        end else begin
                            hold_d  = hold_q - phase_t'(1);
                        end
                    end
                    default: begin
                        if (cnt_q != PHASE_MAX) begin
                            cnt_d = cnt_q + phase_t'(1);
                        end else begin
                            spike_d = 1'b1;
                            pend_d  = 1'b0;
                            cnt_d   = '0;
                            if (pend_q && (pamt_q != '0)) begin
                                if (pdir_q) begin
                                    cnt_d   = pamt_q;
                                end else begin
                                    hold_d  = pamt_q;
                                    state_d = HOLD;
                                end
                            end
                        end
                    end
                endcase
            end

            // Captured after the wrap logic so a same-cycle transfer waits for the next wrap.
            if (w_xfer) begin
                pend_d = 1'b1;
                pdir_d = adj.adj_dir;
                pamt_d = adj.adj_amt;
            end
        end

        holding_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STOP;
            resume_q  <= RUN;
            cnt_q     <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            pdir_q    <= 1'b0;
            pamt_q    <= '0;
            spike_q   <= 1'b0;
            holding_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            pdir_q    <= pdir_d;
            pamt_q    <= pamt_d;
            spike_q   <= spike_d;
            holding_q <= holding_d;
        end
    end

    assign spike         = spike_q;
    assign phase         = cnt_q;
    assign holding       = holding_q;
    assign adj.adj_ready = !pend_q;

endmodule : neuron_osc

`default_nettype wire
